// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM with memory-wait timeout.
// Illegal opcodes and stalled memory park the core in TRAP until reset.
module multicycle_controller #(
  parameter int WAIT_MAX = 15,
  parameter int JAL_EN   = 1,
  parameter int ADDI_EN  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op_code,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       alu_src_a,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic [1:0] fault
);

  localparam int CW =
    (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] LIM =
    CW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MADDR  = 4'd2;
  localparam logic [3:0] S_MRD    = 4'd3;
  localparam logic [3:0] S_MWB    = 4'd4;
  localparam logic [3:0] S_MWR    = 4'd5;
  localparam logic [3:0] S_REXEC  = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_JAL    = 4'd10;
  localparam logic [3:0] S_AEXEC  = 4'd11;
  localparam logic [3:0] S_AWB    = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;
  localparam logic [3:0] S_IDLE   = 4'd14;

  logic [3:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_fault;
  logic [5:0]    r_op;
  logic [3:0]    w_next;
  logic          w_wait;
  logic          w_tmo;

  assign w_wait = (r_state == S_FETCH) ||
                  (r_state == S_MRD) ||
                  (r_state == S_MWR);
  // The current low cycle counts toward the limit.
  assign w_tmo = (WAIT_MAX != 0) && !mem_ready &&
                 (r_cnt == LIM);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:
        if (mem_ready)  w_next = S_DECODE;
        else if (w_tmo) w_next = S_TRAP;
      S_DECODE:
        case (op_code)
          6'b000000: w_next = S_REXEC;
          6'b100011,
          6'b101011: w_next = S_MADDR;
          6'b000100: w_next = S_BRANCH;
          6'b000010: w_next = S_JUMP;
          6'b000011:
            w_next = (JAL_EN != 0) ? S_JAL : S_TRAP;
          6'b001000:
            w_next = (ADDI_EN != 0) ? S_AEXEC : S_TRAP;
          default:   w_next = S_TRAP;
        endcase
      S_MADDR:
        w_next = (r_op == 6'b100011) ? S_MRD : S_MWR;
      S_MRD:
        if (mem_ready)  w_next = S_MWB;
        else if (w_tmo) w_next = S_TRAP;
      S_MWR:
        if (mem_ready)  w_next = S_FETCH;
        else if (w_tmo) w_next = S_TRAP;
      S_MWB, S_RWB, S_BRANCH, S_JUMP,
      S_JAL, S_AWB: w_next = S_FETCH;
      S_REXEC:  w_next = S_RWB;
      S_AEXEC:  w_next = S_AWB;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_fault <= 2'b00;
      r_op    <= 6'b000000;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_op <= op_code;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_wait && !mem_ready && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
      if (w_next == S_TRAP && r_state != S_TRAP)
        r_fault <= (r_state == S_DECODE) ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    alu_src_a  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    unique case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MADDR, S_AEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      S_JAL: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
      end
      S_AWB: reg_write = 1'b1;
      default: ;
    endcase
  end

  assign state = r_state;
  assign fault = r_fault;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: default, WAIT_MAX=4
// and JAL_EN=0 instances share one stimulus stream.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op_code = 6'd0;
  logic       mem_ready = 1'b0;
  logic       zero = 1'b0;

  wire [16:0] o0, o1, o2;
  wire [3:0]  st0, st1, st2;
  wire [1:0]  f0, f1, f2;

  int n_chk = 0;
  int n_pass = 0;
  int n_ir = 0;
  int n_badreg = 0;

  // {pc_write,i_or_d,mem_read,mem_write,ir_write,alu_src_a,
  //  reg_write,reg_dst,mem_to_reg,alu_src_b,alu_op,pc_source}
  localparam logic [16:0] Z    = 17'd0;
  localparam logic [16:0] F_W  = 17'b0_0_1_0_0_0_0_00_00_01_00_00;
  localparam logic [16:0] F_R  = 17'b1_0_1_0_1_0_0_00_00_01_00_00;
  localparam logic [16:0] DEC  = 17'b0_0_0_0_0_0_0_00_00_11_00_00;
  localparam logic [16:0] MAD  = 17'b0_0_0_0_0_1_0_00_00_10_00_00;
  localparam logic [16:0] MRD  = 17'b0_1_1_0_0_0_0_00_00_00_00_00;
  localparam logic [16:0] MWB  = 17'b0_0_0_0_0_0_1_00_01_00_00_00;
  localparam logic [16:0] MWR  = 17'b0_1_0_1_0_0_0_00_00_00_00_00;
  localparam logic [16:0] REX  = 17'b0_0_0_0_0_1_0_00_00_00_10_00;
  localparam logic [16:0] RWB  = 17'b0_0_0_0_0_0_1_01_00_00_00_00;
  localparam logic [16:0] BR1  = 17'b1_0_0_0_0_1_0_00_00_00_01_01;
  localparam logic [16:0] BR0  = 17'b0_0_0_0_0_1_0_00_00_00_01_01;
  localparam logic [16:0] JMP  = 17'b1_0_0_0_0_0_0_00_00_00_00_10;
  localparam logic [16:0] JAL  = 17'b1_0_0_0_0_0_1_10_10_00_00_10;
  localparam logic [16:0] AWB  = 17'b0_0_0_0_0_0_1_00_00_00_00_00;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_ADI = 6'b001000;

  always #5 clk = ~clk;

  multicycle_controller u0 (
    .clk(clk), .rst_n(rst_n), .op_code(op_code),
    .mem_ready(mem_ready), .zero(zero),
    .pc_write(o0[16]), .i_or_d(o0[15]),
    .mem_read(o0[14]), .mem_write(o0[13]),
    .ir_write(o0[12]), .alu_src_a(o0[11]),
    .reg_write(o0[10]), .reg_dst(o0[9:8]),
    .mem_to_reg(o0[7:6]), .alu_src_b(o0[5:4]),
    .alu_op(o0[3:2]), .pc_source(o0[1:0]),
    .state(st0), .fault(f0)
  );

  multicycle_controller #(.WAIT_MAX(4)) u1 (
    .clk(clk), .rst_n(rst_n), .op_code(op_code),
    .mem_ready(mem_ready), .zero(zero),
    .pc_write(o1[16]), .i_or_d(o1[15]),
    .mem_read(o1[14]), .mem_write(o1[13]),
    .ir_write(o1[12]), .alu_src_a(o1[11]),
    .reg_write(o1[10]), .reg_dst(o1[9:8]),
    .mem_to_reg(o1[7:6]), .alu_src_b(o1[5:4]),
    .alu_op(o1[3:2]), .pc_source(o1[1:0]),
    .state(st1), .fault(f1)
  );

  multicycle_controller #(.JAL_EN(0)) u2 (
    .clk(clk), .rst_n(rst_n), .op_code(op_code),
    .mem_ready(mem_ready), .zero(zero),
    .pc_write(o2[16]), .i_or_d(o2[15]),
    .mem_read(o2[14]), .mem_write(o2[13]),
    .ir_write(o2[12]), .alu_src_a(o2[11]),
    .reg_write(o2[10]), .reg_dst(o2[9:8]),
    .mem_to_reg(o2[7:6]), .alu_src_b(o2[5:4]),
    .alu_op(o2[3:2]), .pc_source(o2[1:0]),
    .state(st2), .fault(f2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic mr, input logic [5:0] op,
                     input logic zr, input logic [3:0] es,
                     input logic [16:0] eo);
    mem_ready = mr;
    op_code = op;
    zero = zr;
    #1;
    chk("state", 32'(st0), 32'(es));
    chk("outs", 32'(o0), 32'(eo));
    if (o0[12]) n_ir++;
    if (o0[10] && st0 != 4'd4) n_badreg++;
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    op_code = 6'd0;
    #1;
    chk("rst_st0", 32'(st0), 32'd14);
    chk("rst_st1", 32'(st1), 32'd14);
    chk("rst_st2", 32'(st2), 32'd14);
    chk("rst_outs", 32'(o0), 32'd0);
    chk("rst_fault0", 32'(f0), 32'd0);
    chk("rst_fault1", 32'(f1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_idle", 32'(st0), 32'd14);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // lw: 3 FETCH stalls, 2 MEM_RD stalls
    cyc(0, 6'd0, 0, 4'd0, F_W);
    cyc(0, 6'd0, 0, 4'd0, F_W);
    cyc(0, 6'd0, 0, 4'd0, F_W);
    cyc(1, 6'd0, 0, 4'd0, F_R);
    cyc(0, OP_LW, 0, 4'd1, DEC);
    cyc(0, 6'd0, 0, 4'd2, MAD);
    cyc(0, 6'd0, 0, 4'd3, MRD);
    cyc(0, 6'd0, 0, 4'd3, MRD);
    cyc(1, 6'd0, 0, 4'd3, MRD);
    cyc(0, 6'd0, 0, 4'd4, MWB);
    chk("lw_irw_once", 32'(n_ir), 32'd1);
    chk("lw_regw_only4", 32'(n_badreg), 32'd0);

    // beq taken then not taken
    cyc(1, 6'd0, 0, 4'd0, F_R);
    cyc(0, OP_BEQ, 0, 4'd1, DEC);
    cyc(0, 6'd0, 1, 4'd8, BR1);
    cyc(1, 6'd0, 0, 4'd0, F_R);
    cyc(0, OP_BEQ, 0, 4'd1, DEC);
    cyc(0, 6'd0, 0, 4'd8, BR0);

    // R-type; opcode noise outside DECODE
    cyc(1, 6'd0, 0, 4'd0, F_R);
    cyc(0, 6'd0, 0, 4'd1, DEC);
    cyc(0, 6'h3f, 0, 4'd6, REX);
    cyc(0, 6'h3f, 0, 4'd7, RWB);

    // sw with one stall
    cyc(1, 6'd0, 0, 4'd0, F_R);
    cyc(0, OP_SW, 0, 4'd1, DEC);
    cyc(0, OP_LW, 0, 4'd2, MAD);
    cyc(0, 6'd0, 0, 4'd5, MWR);
    cyc(1, 6'd0, 0, 4'd5, MWR);

    // j, addi
    cyc(1, 6'd0, 0, 4'd0, F_R);
    cyc(0, OP_J, 0, 4'd1, DEC);
    cyc(0, 6'd0, 0, 4'd9, JMP);
    cyc(1, 6'd0, 0, 4'd0, F_R);
    cyc(0, OP_ADI, 0, 4'd1, DEC);
    cyc(0, 6'd0, 0, 4'd11, MAD);
    cyc(0, 6'd0, 0, 4'd12, AWB);

    // jal: legal on u0, illegal on u2
    cyc(1, 6'd0, 0, 4'd0, F_R);
    cyc(0, OP_JAL, 0, 4'd1, DEC);
    mem_ready = 1'b0;
    op_code = 6'd0;
    #1;
    chk("jal_st", 32'(st0), 32'd10);
    chk("jal_outs", 32'(o0), 32'(JAL));
    chk("nojal_st", 32'(st2), 32'd13);
    chk("nojal_fault", 32'(f2), 32'd1);
    chk("nojal_outs", 32'(o2), 32'd0);
    tick();

    // WAIT_MAX=4 stuck in MEM_WR
    cyc(1, 6'd0, 0, 4'd0, F_R);
    cyc(0, OP_SW, 0, 4'd1, DEC);
    cyc(0, 6'd0, 0, 4'd2, MAD);
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b0;
      #1;
      chk("tmo_wait1", 32'(st1), 32'd5);
      chk("tmo_wait0", 32'(st0), 32'd5);
      tick();
    end
    chk("tmo_trap", 32'(st1), 32'd13);
    chk("tmo_fault", 32'(f1), 32'd2);
    chk("tmo_outs", 32'(o1), 32'd0);
    chk("tmo_u0_wait", 32'(st0), 32'd5);
    mem_ready = 1'b1;
    #1;
    chk("tmo_hold_outs", 32'(o1), 32'd0);
    tick();
    chk("tmo_u0_done", 32'(st0), 32'd0);
    chk("tmo_hold_st", 32'(st1), 32'd13);
    chk("tmo_hold_flt", 32'(f1), 32'd2);

    // illegal opcode, held until reset
    do_reset();
    cyc(1, 6'd0, 0, 4'd0, F_R);
    cyc(0, 6'h3f, 0, 4'd1, DEC);
    chk("ill_fault", 32'(f0), 32'd1);
    cyc(1, 6'd0, 0, 4'd13, Z);
    cyc(0, OP_LW, 1, 4'd13, Z);
    cyc(1, OP_J, 0, 4'd13, Z);
    chk("ill_fault_hold", 32'(f0), 32'd1);
    do_reset();

    // stalls end exactly at the WAIT_MAX=4 limit
    cyc(0, 6'd0, 0, 4'd0, F_W);
    cyc(0, 6'd0, 0, 4'd0, F_W);
    cyc(0, 6'd0, 0, 4'd0, F_W);
    cyc(1, 6'd0, 0, 4'd0, F_R);
    chk("lim_fetch", 32'(st1), 32'd1);
    cyc(0, OP_SW, 0, 4'd1, DEC);
    cyc(0, 6'd0, 0, 4'd2, MAD);
    cyc(0, 6'd0, 0, 4'd5, MWR);
    cyc(0, 6'd0, 0, 4'd5, MWR);
    cyc(0, 6'd0, 0, 4'd5, MWR);
    mem_ready = 1'b1;
    #1;
    chk("lim_mwr_st", 32'(st1), 32'd5);
    tick();
    chk("lim_mwr_done", 32'(st1), 32'd0);
    chk("lim_no_fault", 32'(f1), 32'd0);

    // async reset in the middle of MEM_RD
    cyc(1, 6'd0, 0, 4'd0, F_R);
    cyc(0, OP_LW, 0, 4'd1, DEC);
    cyc(0, 6'd0, 0, 4'd2, MAD);
    cyc(0, 6'd0, 0, 4'd3, MRD);
    mem_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_st", 32'(st0), 32'd14);
    chk("arst_outs", 32'(o0), 32'd0);
    chk("arst_fault", 32'(f0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_rel", 32'(st0), 32'd14);
    tick();
    chk("arst_fetch", 32'(st0), 32'd0);
    chk("arst_fouts", 32'(o0), 32'(F_W));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
